byte_striping: RTL

- Upstream partner of the two-lane un-striping stage, running in the same clk_2f domain.
- Takes one 32-bit word stream with a valid and distributes consecutive words alternately onto lane 0 and lane 1.
- Each lane output is held for two clk_2f cycles, so the downstream un-striper, whose free-running selector starts at 0 after reset, recovers the original word order.
- Also provides a link-activity FSM and a saturating word counter for debug and status.

---
 rtl/byte_striping.sv | 94 +++++++++
 1 files changed

// File: rtl/byte_striping.sv
// Byte striping: alternates consecutive input words onto two lanes, each held for
// two clk_2f cycles, with a link-activity FSM and a saturating accepted-word counter.
module byte_striping #(
   parameter int DATA_WIDTH = 32,
   parameter int IDLE_LIMIT = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_2f,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] lane_0,
   output logic [DATA_WIDTH-1:0] lane_1,
   output logic                  valid_0,
   output logic                  valid_1,
   output logic                  active,
   output logic [CNT_WIDTH-1:0]  word_count
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [3:0] IDLE_LAST = 4'(IDLE_LIMIT - 1);

   logic       sel_p0;
   state_t     state;
   logic [3:0] idle_cnt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // Capture stage: free-running selector steers each edge's sample to one lane
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         sel_p0  <= 1'b0;
         lane_0  <= '0;
         lane_1  <= '0;
         valid_0 <= 1'b0;
         valid_1 <= 1'b0;
      end else begin
         sel_p0 <= ~sel_p0;
         if (!sel_p0) begin
            lane_0  <= valid_in ? data_in : '0;
            valid_0 <= valid_in;
         end else begin
            lane_1  <= valid_in ? data_in : '0;
            valid_1 <= valid_in;
         end
      end
   end

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         word_count <= '0;
      end else if (valid_in) begin
         word_count <= sat_inc(word_count);
      end
   end

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         active   <= 1'b0;
         idle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (valid_in) begin
                  state  <= ACTIVE;
                  active <= 1'b1;
               end
            end
            ACTIVE: begin
               if (valid_in) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IDLE_LAST) begin
                  state    <= IDLE;
                  active   <= 1'b0;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 4'd1;
               end
            end
            default: begin
               state    <= IDLE;
               active   <= 1'b0;
               idle_cnt <= '0;
            end
         endcase
      end
   end

endmodule
